mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage access controller between the processor's memory stage and a multi-cycle backing data memory. It latches a load/store request, runs the request/acknowledge handshake, stalls the pipeline until the access completes, and returns load data. A single-entry last-read buffer lets a repeated load complete without a backing-memory access. It detects illegal accesses and handshake timeouts.

## Interface
- TIMEOUT, 16: maximum WAIT cycles without `mm_ack` before error; legal range 2..255.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Addr  in  16  byte address from memory stage; must be even.
- DataIn  in  16  store data.
- Rd  in  1  load request.
- Wr  in  1  store request.
- createdump  in  1  dump request (halt).
- DataOut  out  16  load data; valid while `Done`=1.
- Done  out  1  access complete, one-cycle pulse.
- Stall  out  1  pipeline must hold memory-stage inputs stable.
- err  out  1  sticky error.
- mm_addr  out  16  backing-memory address (registered).
- mm_wdata  out  16  backing-memory write data (registered).
- mm_req  out  1  backing-memory request, one cycle.
- mm_we  out  1  write qualifier for `mm_req`.
- mm_dump  out  1  backing-memory dump pulse.
- mm_rdata  in  16  read data, valid with `mm_ack`.
- mm_ack  in  1  backing-memory completion pulse.

## Operation
- Reset (`rst`=0, any time, including mid-access): state IDLE; buffer invalid; every output 0; the WAIT counter is cleared. A reset during WAIT abandons the access, and any later `mm_ack` is ignored until a new request is issued.
- States: IDLE, REQ, WAIT, DONE, ERR.
- **IDLE**
  - A request exists when `Rd`|`Wr`=1.
  - An illegal request goes to ERR next cycle. Illegal means `Rd`&`Wr`=1, or a request with `Addr[0]`=1.
  - A load hit goes to DONE. A hit is `Rd`, buffer valid, and buffer tag == `Addr`. `DataOut` is loaded from the buffer.
  - Any other request latches `Addr`, `DataIn` and the op into `mm_addr`/`mm_wdata`/`mm_we`, then goes to REQ.
  - `createdump`=1 with no request: `mm_dump`=1 for the next cycle, buffer is invalidated, state stays IDLE. `createdump` together with a request: the request is served and the dump is ignored.
- **REQ**: `mm_req`=1 for exactly this cycle, then WAIT. `mm_ack` is ignored in REQ.
- **WAIT**
  - The counter increments each cycle without `mm_ack`.
  - On `mm_ack` the state goes to DONE.
    - Load: `DataOut`←`mm_rdata`, buffer←{valid, tag=`mm_addr`, `mm_rdata`}.
    - Store: if buffer valid and tag==`mm_addr`, buffer data←`mm_wdata` (write-through coherency). Otherwise the buffer is unchanged.
  - When the counter reaches TIMEOUT-1 with no ack, the state goes to ERR.
- **DONE**: `Done`=1 for one cycle, then IDLE. `DataOut` holds its value until the next load completes. For stores, `DataOut` is unchanged.
- **ERR**: `err`=1, `Stall`=1, `Done`=0, `mm_req`=0. Stays in ERR until reset.
- `Stall` is combinational:
  - =1 in IDLE when a request is present and it is not a hit;
  - =1 in IDLE when a hit is present;
  - =1 in REQ, WAIT and ERR;
  - =0 in DONE and in IDLE with no request.

## Timing
- Cycle 0 is the cycle the request is first seen in IDLE.
- Hit: `Stall`=1 at cycle 0; `Done`=1 and `Stall`=0 at cycle 1. Latency 1.
- Miss: `mm_req`=1 at cycle 1. The earliest ack is at cycle 2, giving `Done` at cycle 3. With the ack at cycle 1+k (k≥1), `Done` is at cycle 2+k.
- Timeout: no ack for TIMEOUT consecutive WAIT cycles gives `err`=1 at cycle TIMEOUT+2.
- Pipeline obligation: the memory stage holds `Addr`/`DataIn`/`Rd`/`Wr` while `Stall`=1. After `Done`, the next request is accepted at the IDLE cycle that follows.
- An `mm_ack` arriving in IDLE, REQ, DONE or ERR is ignored and causes no error.
- Back-to-back: a request asserted in the DONE cycle is not sampled. It is serviced starting in the next (IDLE) cycle.

## Test plan
- Reset, then a load of 0x0010 with ack 3 cycles after `mm_req` (memory returns 0xBEEF) -> `mm_req` at cycle 1; `Done`=1 at cycle 5 with `DataOut`=0xBEEF; `Stall`=1 at cycles 0-4.
- Repeat the load of 0x0010 -> no `mm_req`; `Done` at cycle 1 with `DataOut`=0xBEEF.
- Store 0x1234 to 0x0010 (acked), then load 0x0010 -> `mm_we`=1 with `mm_wdata`=0x1234; the following load hits and returns 0x1234 with no `mm_req`.
- Load of 0x0011, and separately `Rd`=`Wr`=1 at 0x0020 -> `err`=1 the next cycle, `Stall` stuck at 1, no `mm_req`. After deasserting then reasserting `rst`: all outputs 0, and a fresh load works.
- TIMEOUT=4, load with no ack -> `err`=1 at cycle 6. A reset asserted mid-WAIT in a separate run -> outputs 0 immediately, and a late `mm_ack` is ignored.
- `createdump` in IDLE after a buffered load -> one-cycle `mm_dump`; a repeat load of the same address then misses (`mm_req`=1).

Source files
------------

// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// Memory-stage access controller: latches a load/store, handshakes with backing memory, returns load data.
// Latency: buffered load hit 1 cycle; miss 2+k cycles for an ack k cycles after mm_req; err TIMEOUT+2 on no ack.
// Backpressure: Stall holds the memory stage while a request is pending; requests are sampled only in IDLE.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err,
    output logic [15:0] mm_addr,
    output logic [15:0] mm_wdata,
    output logic        mm_req,
    output logic        mm_we,
    output logic        mm_dump,
    input  logic [15:0] mm_rdata,
    input  logic        mm_ack
);

    // The wait counter is 8 bits wide, so TIMEOUT must fit in 2..255.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT out of range 2..255");
    end

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    // Single-entry last-read buffer; tag is the full byte address of the load.
    typedef struct packed {
        logic        vld;
        logic [15:0] tag;
        logic [15:0] dat;
    } rbuf_t;

    state_t      state;
    rbuf_t       rbuf;
    logic [7:0]  wait_cnt;

    logic        req_present;
    logic        req_illegal;
    logic        req_hit;

    // Request classification for the IDLE-state decision; illegal takes precedence over hit.
    assign req_present = Rd | Wr;
    assign req_illegal = (Rd & Wr) | (req_present & Addr[0]);
    assign req_hit     = Rd & ~Wr & rbuf.vld & (rbuf.tag == Addr);

    // Stall: hold the pipeline whenever a request is outstanding or the block is wedged in ERR.
    always_comb begin
        Stall = 1'b0;
        case (state)
            S_IDLE:               Stall = req_present;
            S_REQ, S_WAIT, S_ERR: Stall = 1'b1;
            default:              Stall = 1'b0;
        endcase
    end

    // Main FSM: state, last-read buffer, wait counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rbuf     <= '0;
            wait_cnt <= '0;
            DataOut  <= '0;
            Done     <= 1'b0;
            err      <= 1'b0;
            mm_addr  <= '0;
            mm_wdata <= '0;
            mm_req   <= 1'b0;
            mm_we    <= 1'b0;
            mm_dump  <= 1'b0;
        end else begin
            // Pulse outputs last exactly one cycle unless re-asserted below.
            Done    <= 1'b0;
            mm_req  <= 1'b0;
            mm_dump <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_present) begin
                        if (req_illegal) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else if (req_hit) begin
                            DataOut <= rbuf.dat;
                            Done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            mm_addr  <= Addr;
                            mm_wdata <= DataIn;
                            mm_we    <= Wr;
                            mm_req   <= 1'b1;
                            state    <= S_REQ;
                        end
                    end else if (createdump) begin
                        // A dump may change memory contents, so the buffered copy is dropped.
                        mm_dump  <= 1'b1;
                        rbuf.vld <= 1'b0;
                    end
                end
                S_REQ: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (mm_ack) begin
                        Done     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_DONE;
                        if (!mm_we) begin
                            DataOut <= mm_rdata;
                            rbuf    <= rbuf_t'{vld: 1'b1, tag: mm_addr, dat: mm_rdata};
                        end else if (rbuf.vld && (rbuf.tag == mm_addr)) begin
                            // Write-through keeps the buffered copy coherent with memory.
                            rbuf.dat <= mm_wdata;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        err      <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_ERR: begin
                    // Terminal until reset.
                    err <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// Bench for mem_access_ctrl: directed vector table, error/reset sequences, then random transactions.
// Each transaction is run to Done/err and its cycle timing and data compared with expectations.
// The memory side is emulated by driving mm_ack a chosen number of cycles after mm_req.
module tb_mem_access_ctrl;

    localparam int TO   = 4;
    localparam int MAXC = 14;

    logic        clk;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic        createdump;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        err;
    logic [15:0] mm_addr;
    logic [15:0] mm_wdata;
    logic        mm_req;
    logic        mm_we;
    logic        mm_dump;
    logic [15:0] mm_rdata;
    logic        mm_ack;

    int checks   = 0;
    int failures = 0;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .Addr       (Addr),
        .DataIn     (DataIn),
        .Rd         (Rd),
        .Wr         (Wr),
        .createdump (createdump),
        .DataOut    (DataOut),
        .Done       (Done),
        .Stall      (Stall),
        .err        (err),
        .mm_addr    (mm_addr),
        .mm_wdata   (mm_wdata),
        .mm_req     (mm_req),
        .mm_we      (mm_we),
        .mm_dump    (mm_dump),
        .mm_rdata   (mm_rdata),
        .mm_ack     (mm_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction: inputs, ack delay (0 = never), and expected cycle numbers (-1 = never).
    typedef struct {
        logic        rd;
        logic        wr;
        logic        dump;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          ack_k;
        logic [15:0] rdata;
        int          exp_req;
        int          exp_done;
        int          exp_err;
        logic [15:0] exp_dout;
        int          exp_stall;
        logic        exp_dump;
    } vec_t;

    function automatic vec_t mk(logic rd, logic wr, logic dump, logic [15:0] addr,
                                logic [15:0] wdata, int k, logic [15:0] rdata,
                                int er, int ed, int ee, logic [15:0] edout, int es, logic edump);
        vec_t v;
        v.rd = rd; v.wr = wr; v.dump = dump; v.addr = addr; v.wdata = wdata;
        v.ack_k = k; v.rdata = rdata; v.exp_req = er; v.exp_done = ed; v.exp_err = ee;
        v.exp_dout = edout; v.exp_stall = es; v.exp_dump = edump;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " DataOut"}, 64'(DataOut), 64'd0);
        chk({tag, " Done"},    64'(Done),    64'd0);
        chk({tag, " Stall"},   64'(Stall),   64'd0);
        chk({tag, " err"},     64'(err),     64'd0);
        chk({tag, " mm_addr"}, 64'(mm_addr), 64'd0);
        chk({tag, " mm_wdata"},64'(mm_wdata),64'd0);
        chk({tag, " mm_req"},  64'(mm_req),  64'd0);
        chk({tag, " mm_we"},   64'(mm_we),   64'd0);
        chk({tag, " mm_dump"}, 64'(mm_dump), 64'd0);
    endtask

    // Assert reset away from the clock edge, verify outputs clear immediately, then release.
    task automatic do_reset(input string tag);
        Rd = 1'b0; Wr = 1'b0; createdump = 1'b0; mm_ack = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero(tag);
        @(posedge clk); #3;
        rst = 1'b1;
    endtask

    // Run one transaction from its cycle 0 until Done, err, dump completion or the cycle budget.
    task automatic apply(input string tag, input vec_t v);
        int          req_c = -1;
        int          req_n = 0;
        int          done_c = -1;
        int          err_c = -1;
        int          stall_n = 0;
        logic        dump_s = 1'b0;
        logic [15:0] dout = '0;
        logic [15:0] r_addr = '0;
        logic [15:0] r_wdata = '0;
        logic        r_we = 1'b0;
        bit          pure_dump = v.dump && !v.rd && !v.wr;
        @(posedge clk); #1;
        Rd = v.rd; Wr = v.wr; Addr = v.addr; DataIn = v.wdata;
        createdump = v.dump; mm_ack = 1'b0; mm_rdata = v.rdata;
        for (int c = 0; c <= MAXC; c++) begin
            #1;
            if (Stall) stall_n++;
            if (mm_req) begin
                req_n++;
                if (req_c < 0) begin
                    req_c = c; r_addr = mm_addr; r_we = mm_we; r_wdata = mm_wdata;
                end
            end
            if (mm_dump) dump_s = 1'b1;
            if (Done && done_c < 0) begin done_c = c; dout = DataOut; end
            if (err && err_c < 0) err_c = c;
            if (done_c >= 0 || err_c >= 0 || (pure_dump && c == 1)) break;
            @(posedge clk); #1;
            createdump = 1'b0;
            mm_ack = (v.ack_k > 0) && (c + 1 == v.ack_k + 1);
        end
        mm_ack = 1'b0;
        chk({tag, " req_cycle"},  64'(req_c),   64'(v.exp_req));
        chk({tag, " req_count"},  64'(req_n),   64'((v.exp_req >= 0) ? 1 : 0));
        chk({tag, " done_cycle"}, 64'(done_c),  64'(v.exp_done));
        chk({tag, " err_cycle"},  64'(err_c),   64'(v.exp_err));
        chk({tag, " stall_cycles"}, 64'(stall_n), 64'(v.exp_stall));
        chk({tag, " dump"},       64'(dump_s),  64'(v.exp_dump));
        if (v.exp_done >= 0) chk({tag, " DataOut"}, 64'(dout), 64'(v.exp_dout));
        if (v.exp_req >= 0) begin
            chk({tag, " mm_addr"},  64'(r_addr),  64'(v.addr));
            chk({tag, " mm_we"},    64'(r_we),    64'(v.wr));
            chk({tag, " mm_wdata"}, 64'(r_wdata), 64'(v.wdata));
        end
    endtask

    vec_t tbl[12];

    // Reference model state: one buffered load plus the last completed load data.
    logic        m_vld;
    logic [15:0] m_tag;
    logic [15:0] m_dat;
    logic [15:0] m_dout;

    initial begin
        vec_t v;
        rst = 1'b0; Addr = '0; DataIn = '0; Rd = 1'b0; Wr = 1'b0;
        createdump = 1'b0; mm_rdata = '0; mm_ack = 1'b0;

        //               rd wr dp addr      wdata     k  rdata     req done err dout      stall dump
        tbl[0]  = mk(1, 0, 0, 16'h0010, 16'h0000, 3, 16'hBEEF,  1,  5, -1, 16'hBEEF, 5, 0);
        tbl[1]  = mk(1, 0, 0, 16'h0010, 16'h0000, 0, 16'h0000, -1,  1, -1, 16'hBEEF, 1, 0);
        tbl[2]  = mk(0, 1, 0, 16'h0010, 16'h1234, 1, 16'h0000,  1,  3, -1, 16'hBEEF, 3, 0);
        tbl[3]  = mk(1, 0, 0, 16'h0010, 16'h0000, 0, 16'h0000, -1,  1, -1, 16'h1234, 1, 0);
        tbl[4]  = mk(0, 1, 0, 16'h0040, 16'h5555, 4, 16'h0000,  1,  6, -1, 16'h1234, 6, 0);
        tbl[5]  = mk(1, 0, 0, 16'h0040, 16'h0000, 2, 16'hA5A5,  1,  4, -1, 16'hA5A5, 4, 0);
        tbl[6]  = mk(0, 0, 1, 16'h0040, 16'h0000, 0, 16'h0000, -1, -1, -1, 16'h0000, 0, 1);
        tbl[7]  = mk(1, 0, 0, 16'h0040, 16'h0000, 1, 16'h0F0F,  1,  3, -1, 16'h0F0F, 3, 0);
        tbl[8]  = mk(1, 0, 1, 16'h0040, 16'h0000, 0, 16'h0000, -1,  1, -1, 16'h0F0F, 1, 0);
        tbl[9]  = mk(0, 1, 0, 16'h0040, 16'h7777, 2, 16'h0000,  1,  4, -1, 16'h0F0F, 4, 0);
        tbl[10] = mk(1, 0, 0, 16'h0040, 16'h0000, 0, 16'h0000, -1,  1, -1, 16'h7777, 1, 0);
        tbl[11] = mk(1, 0, 0, 16'h0010, 16'h0000, 1, 16'hCAFE,  1,  3, -1, 16'hCAFE, 3, 0);

        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 12; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Misaligned load wedges in ERR; later acks and held requests change nothing.
        apply("misaligned", mk(1, 0, 0, 16'h0011, 16'h0000, 0, 16'h0000, -1, -1, 1, 16'h0, 2, 0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            mm_ack = (c == 1);
            #1;
            chk($sformatf("err_hold%0d err", c),   64'(err),    64'd1);
            chk($sformatf("err_hold%0d stall", c), 64'(Stall),  64'd1);
            chk($sformatf("err_hold%0d req", c),   64'(mm_req), 64'd0);
            chk($sformatf("err_hold%0d done", c),  64'(Done),   64'd0);
        end
        do_reset("rst_after_err");
        // Reset cleared the buffer, so an address buffered before is a miss again.
        apply("post_err_load", mk(1, 0, 0, 16'h0040, 16'h0000, 1, 16'h2468, 1, 3, -1, 16'h2468, 3, 0));

        apply("rd_and_wr", mk(1, 1, 0, 16'h0020, 16'h9999, 0, 16'h0000, -1, -1, 1, 16'h0, 2, 0));
        do_reset("rst_after_rdwr");

        apply("timeout", mk(1, 0, 0, 16'h0080, 16'h0000, 0, 16'h0000, 1, -1, TO + 2, 16'h0, TO + 3, 0));
        do_reset("rst_after_timeout");

        // Reset in the middle of WAIT, then a stray ack must be ignored.
        @(posedge clk); #1;
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0050; mm_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midwait stall", 64'(Stall), 64'd1);
        Rd = 1'b0;
        #1 rst = 1'b0;
        #1 check_zero("rst_midwait");
        @(posedge clk); #3;
        rst = 1'b1;
        mm_rdata = 16'hDEAD;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            mm_ack = (c == 0);
            #1;
            chk($sformatf("late_ack%0d done", c), 64'(Done),   64'd0);
            chk($sformatf("late_ack%0d err", c),  64'(err),    64'd0);
            chk($sformatf("late_ack%0d req", c),  64'(mm_req), 64'd0);
        end
        mm_ack = 1'b0;
        apply("post_midwait_load", mk(1, 0, 0, 16'h0050, 16'h0000, 2, 16'h1357, 1, 4, -1, 16'h1357, 4, 0));

        // Random transactions against a transaction-level model from a clean reset.
        do_reset("rst_before_random");
        m_vld = 1'b0; m_tag = '0; m_dat = '0; m_dout = '0;
        for (int n = 0; n < 60; n++) begin
            int op = $urandom_range(0, 99);
            int k  = $urandom_range(1, TO);
            v.rd    = (op < 60);
            v.wr    = (op >= 60) && (op < 88);
            v.dump  = (op >= 88) || ($urandom_range(0, 7) == 0);
            v.addr  = 16'(16'h0010 * $urandom_range(1, 4));
            v.wdata = 16'($urandom);
            v.rdata = 16'($urandom);
            v.ack_k = k;
            v.exp_req = -1; v.exp_done = -1; v.exp_err = -1;
            v.exp_stall = 0; v.exp_dump = 1'b0;
            if (!v.rd && !v.wr) begin
                v.exp_dump = 1'b1;
                m_vld = 1'b0;
            end else if (v.rd && m_vld && m_tag == v.addr) begin
                v.exp_done = 1; v.exp_stall = 1;
                m_dout = m_dat;
            end else begin
                v.exp_req = 1; v.exp_done = 2 + k; v.exp_stall = 2 + k;
                if (v.rd) begin
                    m_dout = v.rdata; m_vld = 1'b1; m_tag = v.addr; m_dat = v.rdata;
                end else if (m_vld && m_tag == v.addr) begin
                    m_dat = v.wdata;
                end
            end
            v.exp_dout = m_dout;
            apply($sformatf("rand%0d", n), v);
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0; createdump = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
